// File: rtl/lcd_timing_pkg.sv
// Shared timing defaults, derived line/frame totals and FSM state encoding for the LCD timing generator.
// Pure definitions: no latency, no flow control.
package lcd_timing_pkg;

  function automatic int seg_total(input int sync, input int bp, input int act, input int fp);
    return sync + bp + act + fp;
  endfunction

  localparam int DEF_CW       = 12;
  localparam int DEF_H_ACTIVE = 480;
  localparam int DEF_H_FP     = 2;
  localparam int DEF_H_SYNC   = 41;
  localparam int DEF_H_BP     = 2;
  localparam int DEF_V_ACTIVE = 272;
  localparam int DEF_V_FP     = 2;
  localparam int DEF_V_SYNC   = 10;
  localparam int DEF_V_BP     = 2;
  localparam int DEF_PRE      = 1;

  localparam int DEF_H_TOTAL = seg_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
  localparam int DEF_V_TOTAL = seg_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tg_state_t;

endpackage

// File: rtl/lcd_tg_counter.sv
// Wrapping counter 0..MAX with terminal-count flag; clr forces zero, inc advances.
// Latency: tc is combinational on the registered count; no backpressure.
module lcd_tg_counter #(
  parameter int W   = 12,
  parameter int MAX = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MAX);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD sync/data-enable timing generator with a PRE-clock-early pixel-fetch request.
// Latency: outputs are 1 clock behind the h/v counters; free-running, no backpressure.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int   CW       = DEF_CW,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PRE      = DEF_PRE
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          sof,
  output logic          sol,
  output logic          busy
);

  localparam int H_TOTAL = seg_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = seg_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;

  if (PRE < 0 || PRE > 3) begin : g_bad_pre
    $error("lcd_timing_gen: PRE must be in 0..3");
  end
  if (H_SYNC + H_BP < PRE) begin : g_bad_lead
    $error("lcd_timing_gen: H_SYNC+H_BP must be >= PRE");
  end
  if (H_ACTIVE < 1 || H_SYNC < 1 || H_BP < 0 || H_FP < 0 ||
      V_ACTIVE < 1 || V_SYNC < 1 || V_BP < 0 || V_FP < 0) begin : g_bad_timing
    $error("lcd_timing_gen: illegal timing parameter");
  end
  if (CW < 2 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
    $error("lcd_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end

  // Decodes run two bits wider than the counters so hc+PRE and the range ends never wrap.
  localparam logic [CW+1:0] HS_END_W = (CW+2)'(H_SYNC);
  localparam logic [CW+1:0] HA0_W    = (CW+2)'(HA0);
  localparam logic [CW+1:0] HA1_W    = (CW+2)'(HA0 + H_ACTIVE);
  localparam logic [CW+1:0] VS_END_W = (CW+2)'(V_SYNC);
  localparam logic [CW+1:0] VA0_W    = (CW+2)'(VA0);
  localparam logic [CW+1:0] VA1_W    = (CW+2)'(VA0 + V_ACTIVE);
  localparam logic [CW+1:0] PRE_W    = (CW+2)'(PRE);

  tg_state_t     state;
  logic          running;
  logic [CW-1:0] hc, vc;
  logic          h_tc, v_tc, frame_end;
  logic [CW+1:0] hc_w, vc_w, hr_w;
  logic          h_sync, v_sync, h_act, v_act, r_act;

  assign running   = (state != ST_IDLE);
  assign frame_end = h_tc && v_tc;

  lcd_tg_counter #(.W(CW), .MAX(H_TOTAL - 1)) u_hcnt (
    .clk (clk),
    .rst (rst),
    .clr (!running),
    .inc (running),
    .cnt (hc),
    .tc  (h_tc)
  );

  lcd_tg_counter #(.W(CW), .MAX(V_TOTAL - 1)) u_vcnt (
    .clk (clk),
    .rst (rst),
    .clr (!running),
    .inc (running && h_tc),
    .cnt (vc),
    .tc  (v_tc)
  );

  assign hc_w   = {2'b00, hc};
  assign vc_w   = {2'b00, vc};
  assign hr_w   = hc_w + PRE_W;
  assign h_sync = (hc_w < HS_END_W);
  assign v_sync = (vc_w < VS_END_W);
  assign h_act  = (hc_w >= HA0_W) && (hc_w < HA1_W);
  assign v_act  = (vc_w >= VA0_W) && (vc_w < VA1_W);
  // The request column stays inside the same line because HA0 >= PRE.
  assign r_act  = (hr_w >= HA0_W) && (hr_w < HA1_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hs    <= !HS_POL;
      vs    <= !VS_POL;
      de    <= 1'b0;
      req   <= 1'b0;
      sof   <= 1'b0;
      sol   <= 1'b0;
      busy  <= 1'b0;
      x     <= '0;
      y     <= '0;
      req_x <= '0;
      req_y <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (en) state <= ST_RUN;
        ST_RUN:   if (!en) state <= frame_end ? ST_IDLE : ST_DRAIN;
        ST_DRAIN: begin
          if (en)             state <= ST_RUN;
          else if (frame_end) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase

      busy <= running;
      if (running) begin
        hs  <= h_sync ? HS_POL : !HS_POL;
        vs  <= v_sync ? VS_POL : !VS_POL;
        de  <= h_act && v_act;
        req <= r_act && v_act;
        sof <= (hc == '0) && (vc == '0);
        sol <= (hc == '0);
        if (h_act && v_act) begin
          x <= CW'(hc_w - HA0_W);
          y <= CW'(vc_w - VA0_W);
        end
        if (r_act && v_act) begin
          req_x <= CW'(hr_w - HA0_W);
          req_y <= CW'(vc_w - VA0_W);
        end
      end else begin
        hs  <= !HS_POL;
        vs  <= !VS_POL;
        de  <= 1'b0;
        req <= 1'b0;
        sof <= 1'b0;
        sol <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench on a shrunken 8x6 frame (48 clocks): active hc 3..6, vc 2..4, PRE=2.
// Outputs sampled on the falling edge; k counts rising edges since rst release.
module tb_lcd_timing_gen;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          hs, vs, de, req, sof, sol, busy;
  logic [CW-1:0] x, y, req_x, req_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .CW(CW), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PRE(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .req(req), .req_x(req_x), .req_y(req_y),
    .sof(sof), .sol(sol), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_hs"},    32'(hs),    1);
    chk({t, "_vs"},    32'(vs),    1);
    chk({t, "_de"},    32'(de),    0);
    chk({t, "_req"},   32'(req),   0);
    chk({t, "_sof"},   32'(sof),   0);
    chk({t, "_sol"},   32'(sol),   0);
    chk({t, "_busy"},  32'(busy),  0);
    chk({t, "_x"},     32'(x),     0);
    chk({t, "_y"},     32'(y),     0);
    chk({t, "_req_x"}, 32'(req_x), 0);
    chk({t, "_req_y"}, 32'(req_y), 0);
  endtask

  initial begin
    int            n_de, n_hsl, n_vsl, n_sof, n_sol, n_busy;
    logic          rq1, rq2;
    logic [CW-1:0] rx1, rx2, ry1, ry2;

    // Reset with en low, then release with en high.
    step(3);
    chk_reset("rst0");
    rst = 1'b0;
    en  = 1'b1;
    step(1);                                  // k=1: RUN entered, outputs not yet decoded
    chk("k1_sof",  32'(sof),  0);
    chk("k1_busy", 32'(busy), 0);
    step(1);                                  // k=2: hc=vc=0 decoded
    chk("k2_sof",  32'(sof),  1);
    chk("k2_sol",  32'(sol),  1);
    chk("k2_busy", 32'(busy), 1);
    chk("k2_hs",   32'(hs),   0);
    chk("k2_vs",   32'(vs),   0);
    chk("k2_de",   32'(de),   0);
    step(1);                                  // k=3: hc=1
    chk("k3_sof", 32'(sof), 0);
    chk("k3_sol", 32'(sol), 0);
    chk("k3_hs",  32'(hs),  0);
    step(1);                                  // k=4: hc=2, sync over
    chk("k4_hs", 32'(hs), 1);

    // First active row (vc=2): req two clocks before de.
    step(14);                                 // k=18: hc=0 vc=2
    chk("k18_req", 32'(req), 0);
    step(1);                                  // k=19: hc=1
    chk("k19_req",   32'(req),   1);
    chk("k19_req_x", 32'(req_x), 0);
    chk("k19_req_y", 32'(req_y), 0);
    chk("k19_de",    32'(de),    0);
    step(1);                                  // k=20
    chk("k20_req_x", 32'(req_x), 1);
    chk("k20_de",    32'(de),    0);
    step(1);                                  // k=21: first de pixel
    chk("k21_de",    32'(de),    1);
    chk("k21_x",     32'(x),     0);
    chk("k21_y",     32'(y),     0);
    chk("k21_req_x", 32'(req_x), 2);

    // Last active pixel and hold afterwards.
    step(19);                                 // k=40: vc=4 hc=6
    chk("k40_de", 32'(de), 1);
    chk("k40_x",  32'(x),  3);
    chk("k40_y",  32'(y),  2);
    step(1);                                  // k=41
    chk("k41_de", 32'(de), 0);
    chk("k41_x",  32'(x),  3);
    chk("k41_y",  32'(y),  2);
    step(9);                                  // k=50: next frame
    chk("k50_sof", 32'(sof), 1);

    // One full frame of aggregate counts plus the req lead on every clock.
    n_de = 0; n_hsl = 0; n_vsl = 0; n_sof = 0; n_sol = 0; n_busy = 0;
    rq1 = 1'b0; rq2 = 1'b0; rx1 = '0; rx2 = '0; ry1 = '0; ry2 = '0;
    for (int i = 0; i < 48; i++) begin
      if (de)   n_de++;
      if (!hs)  n_hsl++;
      if (!vs)  n_vsl++;
      if (sof)  n_sof++;
      if (sol)  n_sol++;
      if (busy) n_busy++;
      if (i >= 2) begin
        chk("lead_req",   32'(rq2), 32'(de));
        chk("lead_req_x", 32'(rx2), 32'(x));
        chk("lead_req_y", 32'(ry2), 32'(y));
      end
      rq2 = rq1; rx2 = rx1; ry2 = ry1;
      rq1 = req; rx1 = req_x; ry1 = req_y;
      step(1);
    end
    chk("frame_de",     n_de,   12);
    chk("frame_hs_low", n_hsl,  12);
    chk("frame_vs_low", n_vsl,  8);
    chk("frame_sof",    n_sof,  1);
    chk("frame_sol",    n_sol,  6);
    chk("frame_busy",   n_busy, 48);

    // Drop en mid-frame: frame completes in DRAIN, then idle.
    step(12);                                 // k=110
    en = 1'b0;
    chk("k110_busy", 32'(busy), 1);
    step(10);                                 // k=120: vc=2 hc=6 of frame 3
    chk("k120_busy", 32'(busy), 1);
    chk("k120_de",   32'(de),   1);
    chk("k120_x",    32'(x),    3);
    chk("k120_y",    32'(y),    0);
    step(25);                                 // k=145: last pixel of frame
    chk("k145_busy", 32'(busy), 1);
    step(1);                                  // k=146: idle
    chk("k146_busy", 32'(busy), 0);
    chk("k146_hs",   32'(hs),   1);
    chk("k146_vs",   32'(vs),   1);
    chk("k146_de",   32'(de),   0);
    step(4);                                  // k=150
    chk("k150_busy", 32'(busy), 0);
    chk("k150_sol",  32'(sol),  0);

    // Restart, then re-raise en during DRAIN: frames stay back to back.
    en = 1'b1;
    step(2);
    chk("r2_sof",  32'(sof),  1);
    chk("r2_busy", 32'(busy), 1);
    step(8);
    en = 1'b0;
    step(10);
    chk("r20_busy", 32'(busy), 1);
    en = 1'b1;
    step(29);
    chk("r49_sof",  32'(sof),  0);
    chk("r49_busy", 32'(busy), 1);
    step(1);
    chk("r50_sof",  32'(sof),  1);
    chk("r50_busy", 32'(busy), 1);
    step(10);                                 // hc=2 vc=1 of second frame
    chk("r60_x",  32'(x),  3);
    chk("r60_y",  32'(y),  2);
    chk("r60_hs", 32'(hs), 1);

    // Reset mid-frame with en high, then clean restart.
    rst = 1'b1;
    step(1);
    chk_reset("rst1");
    rst = 1'b0;
    step(1);
    chk("rr1_sof",  32'(sof),  0);
    chk("rr1_busy", 32'(busy), 0);
    step(1);
    chk("rr2_sof",  32'(sof),  1);
    chk("rr2_busy", 32'(busy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameter CW, default 12: width of the internal h/v counters and the coordinate outputs.
REQ-002 Parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 480/2/41/2: horizontal timing in pixel clocks.
REQ-003 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 272/2/10/2: vertical timing in lines.
REQ-004 Parameters HS_POL/VS_POL, defaults 0/0: asserted level of hs/vs.
REQ-005 Parameter PRE, default 1, legal range 0..3: the number of clocks by which req leads de.
REQ-006 clk  input  1  pixel clock; the single clock of the block.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 en  input  1  run request; level-sensitive.
REQ-009 hs  output  1  horizontal sync, registered.
REQ-010 vs  output  1  vertical sync, registered.
REQ-011 de  output  1  display-data valid, registered.
REQ-012 x  output  CW  column of the current de pixel, 0..H_ACTIVE-1.
REQ-013 y  output  CW  row of the current de pixel, 0..V_ACTIVE-1.
REQ-014 req  output  1  pixel-fetch request, PRE clocks ahead of de.
REQ-015 req_x  output  CW  column for req; req_y  output  CW  row for req.
REQ-016 sof  output  1  one-clock pulse on the first clock of each frame.
REQ-017 sol  output  1  one-clock pulse on the first clock of each line.
REQ-018 busy  output  1  high while a frame is in progress.

Function
REQ-019 H_TOTAL SHALL equal H_SYNC+H_BP+H_ACTIVE+H_FP, and V_TOTAL SHALL equal V_SYNC+V_BP+V_ACTIVE+V_FP.
REQ-020 Line order SHALL be sync, back porch, active, front porch: hc 0..H_SYNC-1 is sync; hc H_SYNC+H_BP .. H_SYNC+H_BP+H_ACTIVE-1 is active.
REQ-021 Frame order SHALL be the same for lines: vc 0..V_SYNC-1 is sync; vc V_SYNC+V_BP .. V_SYNC+V_BP+V_ACTIVE-1 is active.
REQ-022 The state machine SHALL have three states: IDLE, RUN and DRAIN.
REQ-023 IDLE->RUN SHALL occur when en=1; hc=vc=0 on the first RUN clock.
REQ-024 RUN->DRAIN SHALL occur when en=0; DRAIN SHALL complete the current frame.
REQ-025 DRAIN->IDLE SHALL occur at hc=H_TOTAL-1, vc=V_TOTAL-1.
REQ-026 DRAIN->RUN SHALL occur when en returns to 1, with no frame interruption.
REQ-027 When en=1 at the end of a frame, RUN SHALL wrap directly to the next frame with no gap.
REQ-028 hc SHALL increment every RUN/DRAIN clock and wrap at H_TOTAL-1.
REQ-029 vc SHALL increment when hc wraps and SHALL itself wrap at V_TOTAL-1.
REQ-030 hs, vs, de, x, y, sof and sol SHALL be registered decodes of (hc,vc), so each appears exactly 1 clock after the counter value it decodes.
REQ-031 vs SHALL change only on a line boundary, coincident with sol.
REQ-032 req/req_x/req_y SHALL equal de/x/y advanced by PRE clocks; PRE=0 makes them identical to de/x/y.
REQ-033 The req lead SHALL hold across line and frame wrap, including the first line after IDLE->RUN.
REQ-034 x and y SHALL hold their last value outside active; x=hc-(H_SYNC+H_BP) and y=vc-(V_SYNC+V_BP), computed at CW bits without overflow.
REQ-035 In IDLE: hs=!HS_POL, vs=!VS_POL, de=req=sof=sol=busy=0, and the counters SHALL be held at 0.
REQ-036 busy SHALL be 1 in RUN and DRAIN, aligned with the registered outputs.

Reset
REQ-037 rst=1 SHALL force, on the next clock edge, state=IDLE, hc=vc=0, hs=!HS_POL, vs=!VS_POL, de=req=sof=sol=busy=0, and x=y=req_x=req_y=0.
REQ-038 rst SHALL override en, including during mid-frame RUN and DRAIN.
REQ-039 After rst falls with en=1, sof SHALL pulse exactly 2 clocks later: 1 clock to enter RUN, 1 register stage.

Structure
REQ-040 Timing defaults, the derived H_TOTAL/V_TOTAL, and the state encoding SHALL live in the shared package lcd_timing_pkg.
REQ-041 One sub-module, lcd_tg_counter (a parametrised wrapping counter with terminal-count output), SHALL be instantiated twice: horizontal and vertical.
REQ-042 Legal ranges of PRE and of the timing parameters SHALL be checked at elaboration; H_BP+H_SYNC >= PRE SHALL be required.

Verification
REQ-043 Defaults, rst then en=1 -> sof 2 clocks after rst release; first de at clock 2+43+240*0... specifically row 0 begins at line 12, col 0 at hc=43; de run length 480.
REQ-044 Defaults, 3 full frames -> sof period 525*286=150150 clocks; exactly 272*480 de clocks per frame; hs low for 41 clocks per line; vs low for 10 lines.
REQ-045 PRE=3 -> req rises 3 clocks before de on every line, and (req_x,req_y) delayed by 3 equals (x,y) at all times.
REQ-046 en dropped at line 100 -> busy stays 1 until frame end, then 1 clock later hs=1, vs=1, de=0; en re-raised mid-DRAIN -> no gap between frames.
REQ-047 rst pulsed at hc=300, vc=150 -> all outputs at reset values the next clock; clean restart with sof 2 clocks after release.
REQ-048 Override CW=10, H_ACTIVE=800, V_ACTIVE=480 -> x reaches 799, y reaches 479, and no wrap errors.
